div32_seq: RTL

Multicycle signed 32-bit divider for the ALU's DIV operation. It takes two's-complement operands, converts them to magnitudes, and runs a 32-iteration restoring shift-subtract loop. It then re-applies the signs through two's-complement negation and returns the quotient (LO) and remainder (HI). It sits beside the combinational ALU operators and is started by the control unit, which waits on `done`.

---
 rtl/div32_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/div32_seq.sv
// ----------------------------------------------------------------------------
// div32_seq
//   Multicycle signed 32-bit divider for the ALU DIV operation. Operands are
//   converted to magnitudes, divided with a 32-iteration restoring
//   shift-subtract loop, and the signs are re-applied at the end. The quotient
//   goes to LO and the remainder to HI. Division truncates toward zero, and
//   the remainder takes the sign of the dividend.
//
//   Latency: 34 cycles from the accepting edge to valid results.
//   Throughput: 35 cycles when operations are issued back to back.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   start        in   request a divide (sampled only while idle)
//   dividend     in   [31:0] signed dividend, captured on the accepting edge
//   divisor      in   [31:0] signed divisor, captured on the accepting edge
//   busy         out  high while an operation is in flight
//   done         out  one-cycle pulse; results are valid from this cycle
//   quotient     out  [31:0] signed quotient (LO)
//   remainder    out  [31:0] signed remainder (HI)
//   div_by_zero  out  set with done when the divisor was 0; held until the
//                     next completion
// ----------------------------------------------------------------------------
module div32_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ITER,
        S_FIX
    } state_t;

    state_t      r_state;
    logic [31:0] r_dividend;
    logic [31:0] r_divisor;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_zero;
    logic [31:0] r_mag_b;
    logic [31:0] r_rem;
    logic [31:0] r_q;
    logic [4:0]  r_count;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;
    logic        r_div_by_zero;

    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    // The partial remainder is always below the divisor magnitude (at most
    // 2^31), so its top bit is never needed between iterations. It only
    // becomes significant after the shift, which is why w_shift is 33 bits
    // while r_rem is stored in 32 bits.
    always_comb begin
        w_mag_a    = r_dividend[31] ? (~r_dividend + 32'd1) : r_dividend;
        w_mag_b    = r_divisor[31]  ? (~r_divisor  + 32'd1) : r_divisor;
        w_shift    = {r_rem, r_q[31]};
        w_trial    = w_shift - {1'b0, r_mag_b};
        w_quot_fix = r_sign_q ? (~r_q + 32'd1) : r_q;
        w_rem_fix  = r_sign_r ? (~r_rem + 32'd1) : r_rem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_sign_q      <= 1'b0;
            r_sign_r      <= 1'b0;
            r_zero        <= 1'b0;
            r_mag_b       <= '0;
            r_rem         <= '0;
            r_q           <= '0;
            r_count       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                        r_sign_q   <= dividend[31] ^ divisor[31];
                        r_sign_r   <= dividend[31];
                        r_busy     <= 1'b1;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_mag_b <= w_mag_b;
                    r_q     <= w_mag_a;
                    r_rem   <= '0;
                    r_count <= '0;
                    r_zero  <= (r_divisor == '0);
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    // A negative trial result means the subtraction does
                    // not fit, so keep the shifted remainder and shift in 0.
                    if (w_trial[32]) begin
                        r_rem <= w_shift[31:0];
                        r_q   <= {r_q[30:0], 1'b0};
                    end else begin
                        r_rem <= w_trial[31:0];
                        r_q   <= {r_q[30:0], 1'b1};
                    end
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_zero) begin
                        r_quotient    <= '1;
                        r_remainder   <= r_dividend;
                        r_div_by_zero <= 1'b1;
                    end else begin
                        r_quotient    <= w_quot_fix;
                        r_remainder   <= w_rem_fix;
                        r_div_by_zero <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
